// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;
  localparam int SRAM_ADDR_W     = 18;
  localparam int DATA_W          = 16;
  localparam int DEF_INDEX_BITS  = 6;
  localparam int DEF_SRAM_WAIT   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/dcache_line_ram.sv
// Valid/tag/data line storage: asynchronous read port, synchronous write port,
// valid bits cleared synchronously on rst (a write in the rst cycle is dropped).
module dcache_line_ram
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_W      = SRAM_ADDR_W - DEF_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_W-1:0]     wr_data
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (wr_en) begin
        tag_q[wr_index]  <= wr_tag;
        data_q[wr_index] <= wr_data;
      end
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of the
// SRAM controller. Optional read hit/miss counters under DCACHE_STATS_EN.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int SRAM_WAIT  = DEF_SRAM_WAIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_rd,
  input  logic                   mem_wr,
  input  logic [SRAM_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]      mem_wdata,
  output logic [DATA_W-1:0]      mem_rdata,
  output logic                   stall,
  output logic [SRAM_ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0]      sram_write_data,
  output logic                   sram_we,
  input  logic [DATA_W-1:0]      sram_read_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
`endif
);
  localparam int TAG_W = SRAM_ADDR_W - INDEX_BITS;
  localparam int CNT_W = $clog2(SRAM_WAIT + 2);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic [DATA_W-1:0]      result_q, result_d;
  logic                   rd_op_q, rd_op_d;

  logic                   line_valid;
  logic [TAG_W-1:0]       line_tag;
  logic [DATA_W-1:0]      line_data;
  logic                   hit;
  logic                   ram_we;
  logic [INDEX_BITS-1:0]  ram_index;
  logic [TAG_W-1:0]       ram_tag;
  logic [DATA_W-1:0]      ram_data;

  assign hit = line_valid && (line_tag == mem_addr[SRAM_ADDR_W-1:INDEX_BITS]);

  dcache_line_ram #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_line_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_index (mem_addr[INDEX_BITS-1:0]),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (ram_we),
    .wr_index (ram_index),
    .wr_tag   (ram_tag),
    .wr_data  (ram_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    result_d  = result_q;
    rd_op_d   = rd_op_q;
    stall     = 1'b0;
    mem_rdata = '0;
    ram_we    = 1'b0;
    ram_index = mem_addr[INDEX_BITS-1:0];
    ram_tag   = mem_addr[SRAM_ADDR_W-1:INDEX_BITS];
    ram_data  = mem_wdata;
    unique case (state_q)
      IDLE: begin
        if (mem_wr) begin
          // Write-through: a hit refreshes the line now; a miss leaves it alone.
          stall   = 1'b1;
          ram_we  = hit;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          we_d    = 1'b1;
          cnt_d   = '0;
          rd_op_d = 1'b0;
          state_d = WR;
        end else if (mem_rd) begin
          if (hit) begin
            mem_rdata = line_data;
          end else begin
            stall   = 1'b1;
            addr_d  = mem_addr;
            we_d    = 1'b0;
            cnt_d   = '0;
            rd_op_d = 1'b1;
            state_d = RD;
          end
        end
      end
      RD: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SRAM_WAIT)) begin
          ram_we    = 1'b1;
          ram_index = addr_q[INDEX_BITS-1:0];
          ram_tag   = addr_q[SRAM_ADDR_W-1:INDEX_BITS];
          ram_data  = sram_read_data;
          result_d  = sram_read_data;
          state_d   = DONE;
        end
      end
      WR: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SRAM_WAIT)) begin
          we_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        mem_rdata = rd_op_q ? result_q : '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      result_q <= '0;
      rd_op_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      result_q <= result_d;
      rd_op_q  <= rd_op_d;
    end
  end

  assign sram_address    = addr_q;
  assign sram_write_data = wdata_q;
  assign sram_we         = we_q;

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_q, hit_d, miss_q, miss_d;

  // A read is counted only in its first (IDLE) cycle; both counters saturate.
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (state_q == IDLE && mem_rd && !mem_wr) begin
      if (hit && hit_q != '1)        hit_d  = hit_q + 16'd1;
      else if (!hit && miss_q != '1) miss_d = miss_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller; expected read results go through a
// scoreboard queue and are compared when the request completes.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd;
  logic        mem_wr;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        stall;
  logic [17:0] sram_address;
  logic [15:0] sram_write_data;
  logic        sram_we;
  logic [15:0] sram_read_data;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  dcache_controller #(
    .INDEX_BITS (6),
    .SRAM_WAIT  (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .stall           (stall),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_we         (sram_we),
    .sram_read_data  (sram_read_data)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a read; counts stall cycles, checks the SRAM read issue, pops the result.
  task automatic do_read(input string tag, input logic [17:0] a, input logic [15:0] sval,
                         input int exp_stalls, input logic [15:0] exp_data);
    int n;
    logic [15:0] exp;
    exp_q.push_back(exp_data);
    @(negedge clk);
    mem_rd = 1'b1; mem_wr = 1'b0; mem_addr = a; sram_read_data = sval;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stall) break;
      n++;
      if (n == 2) begin
        check({tag, "_sram_addr"}, 32'(sram_address), 32'(a));
        check({tag, "_sram_we"}, 32'(sram_we), 32'd0);
      end
      @(negedge clk);
    end
    check({tag, "_stalls"}, n, exp_stalls);
    exp = exp_q.pop_front();
    check({tag, "_rdata"}, 32'(mem_rdata), 32'(exp));
    @(negedge clk);
    mem_rd = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [17:0] a, input logic [15:0] d);
    int n;
    int we_n;
    logic [15:0] exp;
    exp_q.push_back(16'h0000);
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b1; mem_addr = a; mem_wdata = d;
    n = 0; we_n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stall) break;
      n++;
      if (sram_we) we_n++;
      if (n == 2) begin
        check({tag, "_sram_addr"}, 32'(sram_address), 32'(a));
        check({tag, "_sram_wdata"}, 32'(sram_write_data), 32'(d));
      end
      @(negedge clk);
    end
    check({tag, "_stalls"}, n, 4);
    check({tag, "_we_cycles"}, we_n, 3);
    check({tag, "_done_we"}, 32'(sram_we), 32'd0);
    exp = exp_q.pop_front();
    check({tag, "_rdata"}, 32'(mem_rdata), 32'(exp));
    @(negedge clk);
    mem_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    sram_read_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rdata", 32'(mem_rdata), 32'd0);
    check("rst_we", 32'(sram_we), 32'd0);
    check("rst_addr", 32'(sram_address), 32'd0);
    check("rst_wdata", 32'(sram_write_data), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
`ifdef DCACHE_STATS_EN
    check("rst_hits", 32'(hit_count), 32'd0);
    check("rst_misses", 32'(miss_count), 32'd0);
`endif

    do_read("miss5", 18'h00005, 16'hBEEF, 4, 16'hBEEF);
    do_read("hit5", 18'h00005, 16'hDEAD, 0, 16'hBEEF);
`ifdef DCACHE_STATS_EN
    check("stat_miss1", 32'(miss_count), 32'd1);
    check("stat_hit1", 32'(hit_count), 32'd1);
`endif

    do_write("wrhit5", 18'h00005, 16'h1234);
    do_read("hit5_new", 18'h00005, 16'hDEAD, 0, 16'h1234);

    do_read("conf45", 18'h00045, 16'h5A5A, 4, 16'h5A5A);
    do_read("conf5", 18'h00005, 16'h1234, 4, 16'h1234);

    do_write("wrmiss10", 18'h00010, 16'hAAAA);
    do_read("miss10", 18'h00010, 16'hAAAA, 4, 16'hAAAA);

    // Evict line 5, then abort a refill of 0x00005 in its second RD cycle.
    do_read("evict45", 18'h00045, 16'h5A5A, 4, 16'h5A5A);
    @(negedge clk);
    mem_rd = 1'b1; mem_addr = 18'h00005; sram_read_data = 16'h4321;
    #1 check("abort_idle_stall", 32'(stall), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; mem_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check("abort_we", 32'(sram_we), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    do_read("post_rst_hit45", 18'h00045, 16'h5A5A, 4, 16'h5A5A);
    do_read("post_rst5", 18'h00005, 16'h7777, 4, 16'h7777);

`ifdef DCACHE_STATS_EN
    @(negedge clk);
    force dut.hit_q = 16'hFFFF;
    #1 release dut.hit_q;
    do_read("sat_hit", 18'h00005, 16'hDEAD, 0, 16'h7777);
    check("stat_hit_sat", 32'(hit_count), 32'hFFFF);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-through, no-write-allocate data cache between the memory stage and the off-chip SRAM controller. Serves read hits combinationally with zero stall. On read misses and all writes it stalls the pipeline and runs a fixed-length SRAM access through the SRAM controller's word interface. Replaces direct memory-stage access to SRAM on the DE2 build.

## Interface
- INDEX_BITS, 6: line index width; 2^INDEX_BITS one-word lines.
- SRAM_WAIT, 2: extra cycles an SRAM access is held after issue; each access lasts SRAM_WAIT+1 cycles.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mem_rd  in  1  read request from memory stage; held while stall=1.
- mem_wr  in  1  write request from memory stage; held while stall=1.
- mem_addr  in  18  word address.
- mem_wdata  in  16  write data.
- mem_rdata  out  16  read data.
- stall  out  1  freeze pipeline (combinational).
- sram_address  out  18  to SRAM controller, registered.
- sram_write_data  out  16  to SRAM controller, registered.
- sram_we  out  1  to SRAM controller, registered, active-high.
- sram_read_data  in  16  from SRAM controller.
- hit_count  out  16  read hits (only with DCACHE_STATS_EN).
- miss_count  out  16  read misses (only with DCACHE_STATS_EN).

## Operation
- Address split: index = mem_addr[INDEX_BITS-1:0], tag = mem_addr[17:INDEX_BITS]. Each line holds a valid bit, a tag and 16-bit data.
- Hit: valid[index] && tag match.
- mem_rd and mem_wr both high: treated as a write.
- States:
  - IDLE
    - Read hit: stall=0; mem_rdata = line data.
    - Read miss: stall=1; latch address; sram_we<=0; go to RD; counter<=0.
    - Write (hit or miss): stall=1; latch address and data; sram_we<=1; go to WR; counter<=0.
      - On a hit, the line data is updated this cycle.
      - On a miss, the line is untouched (no allocate).
    - No request: stall=0; mem_rdata=0.
  - RD
    - stall=1; counter increments.
    - When counter==SRAM_WAIT: capture sram_read_data into the line and a result register; set valid and tag; go to DONE.
  - WR
    - stall=1; sram_we held 1.
    - When counter==SRAM_WAIT: sram_we<=0; go to DONE.
  - DONE
    - stall=0; mem_rdata = result register for a read, 0 for a write.
    - The held request is consumed here and is not re-issued. Next state is IDLE.
- sram_address and sram_write_data keep their last value outside accesses.

## Timing
- Read hit: zero-cycle latency; data valid in the request cycle.
- Read miss or any write: stall high for SRAM_WAIT+2 cycles (IDLE cycle plus SRAM_WAIT+1 access cycles). Request completes in the following DONE cycle.
  - With the default SRAM_WAIT=2: 4 stall cycles; data is delivered in cycle 5.
- Back-to-back requests: a new request can be accepted in the cycle after DONE.
- Reset values:
  - state=IDLE, stall=0 (absent request), mem_rdata=0.
  - sram_we=0, sram_address=0, sram_write_data=0.
  - All valid bits cleared; counters=0.
- rst mid-access: abort immediately. Next cycle is IDLE with sram_we=0 and all lines invalid; any line being filled is not written.

## Configuration
- DCACHE_STATS_EN defined:
  - hit_count and miss_count ports exist.
  - Each increments by 1 on a read hit or read miss detected in IDLE (a read is counted once, in its first cycle only).
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

## Structure
- Package dcache_pkg:
  - State enum (IDLE, RD, WR, DONE).
  - SRAM_ADDR_W=18, DATA_W=16.
  - Default INDEX_BITS and SRAM_WAIT constants.
- Sub-module dcache_line_ram:
  - Valid, tag and data arrays with one asynchronous read port and one synchronous write port.
  - Synchronous valid clear on rst.
- FSM, counters and SRAM drive live in dcache_controller.

## Test plan
- Defaults used throughout: INDEX_BITS=6, SRAM_WAIT=2.
- After rst, read 0x00005 with the SRAM model returning 0xBEEF:
  - Expect 4 stall cycles, sram_address=0x00005, sram_we=0, then mem_rdata=0xBEEF with stall=0.
  - Re-read of 0x00005: hit, stall=0, 0xBEEF in the same cycle.
- Write 0x00005 data 0x1234 (hit):
  - Expect sram_we=1 for 3 cycles with address 0x00005 and data 0x1234, and stall for 4 cycles.
  - Following read of 0x00005: hit returning 0x1234.
- Conflict:
  - Read 0x00045 (index 5, tag 1): miss, line replaced.
  - Then read 0x00005: miss again, SRAM read issued.
- Write miss 0x00010 data 0xAAAA:
  - SRAM write issued; line 0x10 stays invalid.
  - Read 0x00010: miss.
- rst asserted in the 2nd RD cycle of a miss on 0x00005:
  - Next cycle: IDLE, sram_we=0, stall=0.
  - Subsequent read of 0x00005: miss.
- With DCACHE_STATS_EN:
  - The first scenario yields miss_count=1, hit_count=1.
  - Force hit_count=0xFFFF, then one more hit: value stays 0xFFFF.
